placement_readback: RTL

- Reader counterpart to the placement engine: once placement finishes, it scans the grid RAM in raster order.
- For every occupied cell it fetches that node's position from the pos_X/pos_Y RAMs and cross-checks it against the cell coordinates.
- It streams one record per placed node over a valid/ready interface and ends with summary counts.
- It sits between the placement memories and the result dump/checker logic, and uses only the memories' read ports.

---
 rtl/placement_readback_if.sv | 14 +
 rtl/placement_readback.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/placement_readback_if.sv
// Record stream from placement_readback to the dump/checker logic.
// Handshake: a record transfers on any cycle where rec_valid && rec_ready; while rec_valid is
// high and rec_ready is low the producer holds every payload field stable.
interface placement_readback_if;
    logic        rec_valid;
    logic        rec_ready;
    logic [31:0] rec_node;
    logic [31:0] rec_x;
    logic [31:0] rec_y;
    logic        rec_err;

    modport master (output rec_valid, rec_node, rec_x, rec_y, rec_err, input rec_ready);
    modport slave  (input rec_valid, rec_node, rec_x, rec_y, rec_err, output rec_ready);
endinterface

// File: rtl/placement_readback.sv
// Raster scan of the placement grid RAM, cross-checking each placed node against pos_X/pos_Y
// and streaming one record per node. Optional checksum enabled by READBACK_CKSUM_EN.
module placement_readback #(
    parameter int N       = 15,
    parameter int N_NODES = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      reGrid,
    output logic [31:0]               addrGrid,
    input  logic [31:0]               doutGrid,
    output logic                      rePX,
    output logic                      rePY,
    output logic [31:0]               addrPX,
    output logic [31:0]               addrPY,
    input  logic [31:0]               doutPX,
    input  logic [31:0]               doutPY,
    placement_readback_if.master      rec,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               placed_count,
    output logic [31:0]               err_count,
    output logic [31:0]               checksum,
    output logic [3:0]                dbg_state_o
);
    localparam logic [31:0]        EMPTY     = 32'hFFFF_FFFF;
    localparam logic [31:0]        LAST_C    = 32'(N * N - 1);
    localparam logic [31:0]        LAST_Y    = 32'(N - 1);
    localparam logic signed [31:0] N_NODES_S = 32'(N_NODES);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_G_RD   = 4'd1,
        S_G_WAIT = 4'd2,
        S_G_CHK  = 4'd3,
        S_P_RD   = 4'd4,
        S_P_WAIT = 4'd5,
        S_P_CHK  = 4'd6,
        S_EMIT   = 4'd7,
        S_NEXT   = 4'd8,
        S_DONE   = 4'd9
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] c_q, c_d, cx_q, cx_d, cy_q, cy_d;
    logic [31:0] v_q, v_d;
    logic        err_q, err_d;
    logic [31:0] placed_q, placed_d, errcnt_q, errcnt_d;
    logic        valid;
`ifdef READBACK_CKSUM_EN
    logic [31:0] cksum_q, cksum_d;
`endif

    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        v_d      = v_q;
        err_d    = err_q;
        placed_d = placed_q;
        errcnt_d = errcnt_q;
`ifdef READBACK_CKSUM_EN
        cksum_d  = cksum_q;
`endif
        reGrid   = 1'b0;
        rePX     = 1'b0;
        valid    = 1'b0;
        done     = 1'b0;
        busy     = (state_q != S_IDLE) && (state_q != S_DONE);
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    c_d      = '0;
                    cx_d     = '0;
                    cy_d     = '0;
                    placed_d = '0;
                    errcnt_d = '0;
`ifdef READBACK_CKSUM_EN
                    cksum_d  = '0;
`endif
                    state_d  = S_G_RD;
                end
            end
            S_G_RD: begin
                reGrid  = 1'b1;
                state_d = S_G_WAIT;
            end
            S_G_WAIT: state_d = S_G_CHK;
            S_G_CHK: begin
                v_d = doutGrid;
                // EMPTY is itself negative, so it must be tested before the range check.
                if (doutGrid == EMPTY) begin
                    state_d = S_NEXT;
                end else if ($signed(doutGrid) < 0 || $signed(doutGrid) >= N_NODES_S) begin
                    err_d   = 1'b1;
                    state_d = S_EMIT;
                end else begin
                    err_d   = 1'b0;
                    state_d = S_P_RD;
                end
            end
            S_P_RD: begin
                rePX    = 1'b1;
                state_d = S_P_WAIT;
            end
            S_P_WAIT: state_d = S_P_CHK;
            S_P_CHK: begin
                err_d   = (doutPX != cx_q) || (doutPY != cy_q);
                state_d = S_EMIT;
            end
            S_EMIT: begin
                valid = 1'b1;
                if (rec.rec_ready) begin
                    placed_d = placed_q + 32'd1;
                    errcnt_d = errcnt_q + {31'd0, err_q};
`ifdef READBACK_CKSUM_EN
                    cksum_d  = {cksum_q[30:0], cksum_q[31]} ^ v_q ^ (cx_q << 8) ^ (cy_q << 16);
`endif
                    state_d  = S_NEXT;
                end
            end
            S_NEXT: begin
                if (c_q == LAST_C) begin
                    state_d = S_DONE;
                end else begin
                    c_d = c_q + 32'd1;
                    if (cy_q == LAST_Y) begin
                        cy_d = '0;
                        cx_d = cx_q + 32'd1;
                    end else begin
                        cy_d = cy_q + 32'd1;
                    end
                    state_d = S_G_RD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            c_q      <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            v_q      <= '0;
            err_q    <= 1'b0;
            placed_q <= '0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            v_q      <= v_d;
            err_q    <= err_d;
            placed_q <= placed_d;
            errcnt_q <= errcnt_d;
        end
    end

`ifdef READBACK_CKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) cksum_q <= '0;
        else       cksum_q <= cksum_d;
    end
    assign checksum = cksum_q;
`else
    assign checksum = '0;
`endif

    assign rePY         = rePX;
    assign addrGrid     = c_q;
    assign addrPX       = v_q;
    assign addrPY       = v_q;
    assign rec.rec_valid = valid;
    assign rec.rec_node  = v_q;
    assign rec.rec_x     = cx_q;
    assign rec.rec_y     = cy_q;
    assign rec.rec_err   = err_q;
    assign placed_count = placed_q;
    assign err_count    = errcnt_q;
    assign dbg_state_o  = state_q;
endmodule
